// File: rtl/tx_pulse_array_if.sv
// Bundle of sequencer-side signals for the transducer pulse array.
//   master : sequencer side (drives timebase, command and configuration writes)
//   slave  : pulse array side (drives per-channel outputs and status)
// Signals:
//   cntr          free-running 32-bit timebase
//   cmd           00 wait_cmd, 01 arm, 10 fire_pulse, 11 reset_module
//   cfg_we/cfg_ch/cfg_delay/cfg_charge   shadow-configuration write port
//   txOutputState per-channel transducer drive
//   isActive      any channel waiting or on
//   allDone       every channel finished its pulse
//   errorFlag     sticky per-channel safety trips
interface tx_pulse_array_if #(
    parameter int unsigned NCH      = 8,
    parameter int unsigned DELAY_W  = 16,
    parameter int unsigned CHARGE_W = 9,
    parameter int unsigned CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) ();
    logic [31:0]         cntr;
    logic [1:0]          cmd;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [DELAY_W-1:0]  cfg_delay;
    logic [CHARGE_W-1:0] cfg_charge;
    logic [NCH-1:0]      txOutputState;
    logic                isActive;
    logic                allDone;
    logic [NCH-1:0]      errorFlag;

    modport master (
        output cntr, cmd, cfg_we, cfg_ch, cfg_delay, cfg_charge,
        input  txOutputState, isActive, allDone, errorFlag
    );

    modport slave (
        input  cntr, cmd, cfg_we, cfg_ch, cfg_delay, cfg_charge,
        output txOutputState, isActive, allDone, errorFlag
    );
endinterface

// File: rtl/tx_pulse_array.sv
// Multi-channel transmit pulse generator. Each channel holds a shadow {delay, charge}
// configuration, captures it into an active pair on arm, and on fire drives one pulse
// from cntr==delay until cntr>=delay+charge, cut short by an on-time safety limit.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  tx_pulse_array_if.slave (timebase, command, config writes, outputs, status)
module tx_pulse_array #(
    parameter int unsigned NCH      = 8,
    parameter int unsigned DELAY_W  = 16,
    parameter int unsigned CHARGE_W = 9,
    parameter int unsigned SAFETY_W = 10
) (
    input logic             clk,
    input logic             rst,
    tx_pulse_array_if.slave bus
);
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StArmed = 3'd1;
    localparam logic [2:0] StWait  = 3'd2;
    localparam logic [2:0] StOn    = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic [1:0] CmdWait  = 2'b00;
    localparam logic [1:0] CmdArm   = 2'b01;
    localparam logic [1:0] CmdFire  = 2'b10;
    localparam logic [1:0] CmdReset = 2'b11;

    logic [NCH-1:0] tx_vec;
    logic [NCH-1:0] err_vec;
    logic [NCH-1:0] busy_d;   // channel's next state is WAIT or ON
    logic [NCH-1:0] done_d;   // channel's next state is DONE
    logic           active_q;
    logic           all_done_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [2:0]          st_q, st_d;
        logic [SAFETY_W-1:0] on_cnt_q, on_cnt_d;
        logic [DELAY_W-1:0]  pd_q, pd_d, sh_delay_q, sh_delay_d;
        logic [CHARGE_W-1:0] ct_q, ct_d, sh_charge_q, sh_charge_d;
        logic                tx_q, tx_d, err_q, err_d;
        logic [SAFETY_W-1:0] cnt_inc;
        logic [32:0]         end_time;
        logic                trip, past_end, hit_delay, we_hit;

        // Count including the current ON cycle; its MSB marks the safety limit.
        assign cnt_inc   = on_cnt_q + SAFETY_W'(1);
        assign trip      = cnt_inc[SAFETY_W-1];
        // 33-bit sum so delay+charge can never wrap below the timebase.
        assign end_time  = 33'(pd_q) + 33'(ct_q);
        assign past_end  = {1'b0, bus.cntr} >= end_time;
        assign hit_delay = bus.cntr == 32'(pd_q);
        // Indices at or above NCH never match any channel, so they are dropped.
        assign we_hit    = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

        always_comb begin
            st_d        = st_q;
            pd_d        = pd_q;
            ct_d        = ct_q;
            err_d       = err_q;
            sh_delay_d  = we_hit ? bus.cfg_delay  : sh_delay_q;
            sh_charge_d = we_hit ? bus.cfg_charge : sh_charge_q;
            unique case (bus.cmd)
                CmdWait: st_d = StIdle;
                CmdReset: begin
                    st_d  = StIdle;
                    err_d = 1'b0;
                    pd_d  = '0;
                    ct_d  = '0;
                end
                // Arm captures the shadow as it was before any same-cycle write.
                CmdArm: begin
                    st_d = StArmed;
                    pd_d = sh_delay_q;
                    ct_d = sh_charge_q;
                end
                CmdFire: begin
                    case (st_q)
                        StArmed: begin
                            if (ct_q == '0)      st_d = StDone;
                            else if (pd_q == '0) st_d = StOn;
                            else                 st_d = StWait;
                        end
                        StWait: if (hit_delay) st_d = StOn;
                        StOn: begin
                            if (trip) begin
                                st_d  = StDone;
                                err_d = 1'b1;
                            end else if (past_end) begin
                                st_d = StDone;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
            on_cnt_d = (st_q == StOn && st_d == StOn) ? cnt_inc : '0;
            tx_d     = (st_d == StOn);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q        <= StIdle;
                on_cnt_q    <= '0;
                pd_q        <= '0;
                ct_q        <= '0;
                sh_delay_q  <= '0;
                sh_charge_q <= '0;
                tx_q        <= 1'b0;
                err_q       <= 1'b0;
            end else begin
                st_q        <= st_d;
                on_cnt_q    <= on_cnt_d;
                pd_q        <= pd_d;
                ct_q        <= ct_d;
                sh_delay_q  <= sh_delay_d;
                sh_charge_q <= sh_charge_d;
                tx_q        <= tx_d;
                err_q       <= err_d;
            end
        end

        assign tx_vec[i]  = tx_q;
        assign err_vec[i] = err_q;
        assign busy_d[i]  = (st_d == StWait) || (st_d == StOn);
        assign done_d[i]  = (st_d == StDone);
    end

    // Status is registered from next-state so it changes on the same edge as the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q   <= 1'b0;
            all_done_q <= 1'b0;
        end else begin
            active_q   <= |busy_d;
            all_done_q <= &done_d;
        end
    end

    assign bus.txOutputState = tx_vec;
    assign bus.errorFlag     = err_vec;
    assign bus.isActive      = active_q;
    assign bus.allDone       = all_done_q;
endmodule

// File: tb/tb_tx_pulse_array.sv
module tb_tx_pulse_array;
    localparam int unsigned NCH      = 6;
    localparam int unsigned DELAY_W  = 16;
    localparam int unsigned CHARGE_W = 9;
    localparam int unsigned SAFETY_W = 10;
    localparam int          LIMIT    = 1 << (SAFETY_W - 1);

    localparam logic [1:0] CWait  = 2'b00;
    localparam logic [1:0] CArm   = 2'b01;
    localparam logic [1:0] CFire  = 2'b10;
    localparam logic [1:0] CReset = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tx_pulse_array_if #(.NCH(NCH), .DELAY_W(DELAY_W), .CHARGE_W(CHARGE_W)) bus ();

    tx_pulse_array #(
        .NCH(NCH), .DELAY_W(DELAY_W), .CHARGE_W(CHARGE_W), .SAFETY_W(SAFETY_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(string name, longint act, longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    // Behavioural model: channel phase, pulse timing by plain integer arithmetic.
    typedef enum int {MIdle, MArmed, MWait, MOn, MDone} phase_t;
    phase_t m_ph  [NCH];
    longint m_sd  [NCH];
    longint m_sc  [NCH];
    longint m_pd  [NCH];
    longint m_ct  [NCH];
    int     m_on  [NCH];
    bit     m_err [NCH];

    function automatic void model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_ph[i] = MIdle; m_sd[i] = 0; m_sc[i] = 0; m_pd[i] = 0; m_ct[i] = 0;
            m_on[i] = 0; m_err[i] = 0;
        end
    endfunction

    function automatic void model_step();
        longint t;
        int     ch;
        t = longint'(bus.cntr);
        for (int i = 0; i < NCH; i++) begin
            case (bus.cmd)
                CWait: m_ph[i] = MIdle;
                CReset: begin
                    m_ph[i] = MIdle; m_err[i] = 0; m_pd[i] = 0; m_ct[i] = 0;
                end
                CArm: begin
                    m_pd[i] = m_sd[i]; m_ct[i] = m_sc[i]; m_ph[i] = MArmed;
                end
                default: begin
                    if (m_ph[i] == MArmed)
                        m_ph[i] = (m_ct[i] == 0) ? MDone : ((m_pd[i] == 0) ? MOn : MWait);
                    else if (m_ph[i] == MWait) begin
                        if (t == m_pd[i]) m_ph[i] = MOn;
                    end else if (m_ph[i] == MOn) begin
                        m_on[i]++;
                        if (m_on[i] >= LIMIT) begin
                            m_ph[i] = MDone; m_err[i] = 1;
                        end else if (t >= m_pd[i] + m_ct[i]) begin
                            m_ph[i] = MDone;
                        end
                    end
                end
            endcase
            if (m_ph[i] != MOn) m_on[i] = 0;
        end
        ch = int'(bus.cfg_ch);
        if (bus.cfg_we && ch < NCH) begin
            m_sd[ch] = longint'(bus.cfg_delay);
            m_sc[ch] = longint'(bus.cfg_charge);
        end
    endfunction

    always @(posedge clk) if (!rst) model_step();

    function automatic logic [NCH-1:0] exp_tx();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = (m_ph[i] == MOn);
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_err();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_err[i];
        return v;
    endfunction

    function automatic logic exp_active();
        logic a = 1'b0;
        for (int i = 0; i < NCH; i++) if (m_ph[i] == MWait || m_ph[i] == MOn) a = 1'b1;
        return a;
    endfunction

    function automatic logic exp_done();
        logic d = 1'b1;
        for (int i = 0; i < NCH; i++) if (m_ph[i] != MDone) d = 1'b0;
        return d;
    endfunction

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("txOutputState", bus.txOutputState, exp_tx());
            check("isActive", bus.isActive, exp_active());
            check("allDone", bus.allDone, exp_done());
            check("errorFlag", bus.errorFlag, exp_err());
        end
    end

    // One clock: inputs applied after a falling edge, held across the rising edge.
    task automatic cyc(input logic [1:0] c, input logic [31:0] t, input bit we = 1'b0,
                       input logic [2:0] ch = 3'd0, input logic [15:0] d = 16'd0,
                       input logic [8:0] q = 9'd0);
        bus.cmd = c; bus.cntr = t; bus.cfg_we = we;
        bus.cfg_ch = ch; bus.cfg_delay = d; bus.cfg_charge = q;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wcfg(input logic [2:0] ch, input logic [15:0] d, input logic [8:0] q);
        cyc(CWait, 32'd0, 1'b1, ch, d, q);
    endtask

    initial begin
        int hi;
        int seen;
        logic [31:0] t;
        bus.cmd = CWait; bus.cntr = '0; bus.cfg_we = 1'b0;
        bus.cfg_ch = '0; bus.cfg_delay = '0; bus.cfg_charge = '0;
        model_clear();
        @(negedge clk);
        check("reset tx", bus.txOutputState, 0);
        check("reset isActive", bus.isActive, 0);
        check("reset allDone", bus.allDone, 0);
        check("reset errorFlag", bus.errorFlag, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Basic pulse: pd=100, ct=50; other channels finish immediately.
        for (int c = 0; c < NCH; c++) wcfg(3'(c), 16'd0, 9'd0);
        wcfg(3'd0, 16'd100, 9'd50);
        cyc(CArm, 32'd90);
        for (int v = 90; v <= 160; v++) begin
            cyc(CFire, 32'(v));
            if (v == 99)  check("pulse pre-rise", bus.txOutputState[0], 0);
            if (v == 100) begin
                check("pulse rise", bus.txOutputState[0], 1);
                check("pulse active", bus.isActive, 1);
            end
            if (v == 149) check("pulse pre-fall", bus.txOutputState[0], 1);
            if (v == 150) begin
                check("pulse fall", bus.txOutputState[0], 0);
                check("pulse allDone", bus.allDone, 1);
                check("pulse inactive", bus.isActive, 0);
            end
        end
        cyc(CWait, 32'd0);

        // Zero delay fires at once; zero charge never pulses.
        wcfg(3'd0, 16'd0, 9'd10);
        wcfg(3'd1, 16'd5, 9'd0);
        cyc(CArm, 32'd0);
        cyc(CFire, 32'd0);
        check("zero delay high", bus.txOutputState[0], 1);
        check("zero charge low", bus.txOutputState[1], 0);
        for (int v = 1; v <= 12; v++) cyc(CFire, 32'(v));
        cyc(CWait, 32'd0);

        // Safety trip with cntr held at 0.
        wcfg(3'd0, 16'd0, 9'd511);
        cyc(CArm, 32'd0);
        hi = 0;
        repeat (530) begin
            cyc(CFire, 32'd0);
            if (bus.txOutputState[0]) hi++;
        end
        check("safety high cycles", hi, 512);
        check("safety flag", bus.errorFlag[0], 1);
        cyc(CWait, 32'd0);
        check("flag after wait", bus.errorFlag[0], 1);
        cyc(CArm, 32'd0);
        repeat (5) cyc(CFire, 32'd0);
        check("flag after refire", bus.errorFlag[0], 1);
        cyc(CReset, 32'd0);
        check("flag after reset_module", bus.errorFlag[0], 0);

        // Shadow write in the arm cycle is seen only by the next arm.
        wcfg(3'd2, 16'd3, 9'd5);
        cyc(CArm, 32'd0, 1'b1, 3'd2, 16'd7, 9'd5);
        for (int v = 0; v <= 15; v++) begin
            cyc(CFire, 32'(v));
            if (v == 3) check("old delay used", bus.txOutputState[2], 1);
        end
        cyc(CWait, 32'd0);
        cyc(CArm, 32'd0);
        for (int v = 0; v <= 15; v++) begin
            cyc(CFire, 32'(v));
            if (v == 3) check("new delay not at 3", bus.txOutputState[2], 0);
            if (v == 7) check("new delay at 7", bus.txOutputState[2], 1);
        end
        cyc(CWait, 32'd0);

        // Asynchronous reset mid-pulse.
        wcfg(3'd0, 16'd0, 9'd100);
        cyc(CArm, 32'd0);
        for (int v = 0; v < 5; v++) cyc(CFire, 32'(v));
        #2 rst = 1'b1;
        model_clear();
        #1;
        check("async rst tx", bus.txOutputState, 0);
        check("async rst isActive", bus.isActive, 0);
        check("async rst allDone", bus.allDone, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int v = 0; v < 20; v++) begin
            cyc(CFire, 32'(v));
            if (bus.txOutputState != 0) seen++;
        end
        check("fire without arm", seen, 0);
        cyc(CWait, 32'd0);

        // Large delay+charge must not wrap.
        wcfg(3'd0, 16'hFFFF, 9'h1FF);
        cyc(CArm, 32'hFFF0);
        for (int v = 32'hFFF0; v <= 32'h10205; v++) begin
            cyc(CFire, 32'(v));
            if (v == 32'hFFFE)  check("wide pre-rise", bus.txOutputState[0], 0);
            if (v == 32'hFFFF)  check("wide rise", bus.txOutputState[0], 1);
            if (v == 32'h101FD) check("wide pre-fall", bus.txOutputState[0], 1);
            if (v == 32'h101FE) check("wide fall", bus.txOutputState[0], 0);
        end
        cyc(CReset, 32'd0);

        // Randomized episodes checked by the model every cycle.
        for (int e = 0; e < 40; e++) begin
            int nw, len;
            nw = int'($urandom_range(1, 4));
            for (int k = 0; k < nw; k++)
                wcfg(3'($urandom_range(0, 7)), 16'($urandom_range(0, 40)),
                     9'($urandom_range(0, 40)));
            if ($urandom_range(0, 4) != 0)
                cyc(CArm, 32'd0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    16'($urandom_range(0, 40)), 9'($urandom_range(0, 40)));
            len = int'($urandom_range(5, 90));
            t = 32'd0;
            for (int k = 0; k < len; k++) begin
                cyc(CFire, t, 1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                    16'($urandom_range(0, 40)), 9'($urandom_range(0, 40)));
                t = t + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd1);
            end
            case ($urandom_range(0, 2))
                0: cyc(CWait, t);
                1: cyc(CReset, t);
                default: cyc(CArm, t);
            endcase
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
